// File: rtl/io_input_unit.sv
// io_input_unit: operator switch input for the IN instruction (write-data select 3'b000).
// Stalls the core until the enter button is pressed, then returns sign-extended switches.
//
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   in_req      : IN instruction pending (level, held until io_ready)
//   sw          : raw switches, sw[0] is the sign bit
//   btn_enter   : raw, bouncing, asynchronous enter button
//   data_out    : latched sign-extended switch value, bit 0 is the MSB
//   io_ready    : one-cycle pulse, data_out is written this cycle
//   stall       : request pending and nothing captured yet
//   wait_led    : waiting for the operator to press enter
module io_input_unit #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_req,
    input  logic [0:SW_WIDTH-1] sw,
    input  logic              btn_enter,
    output logic [0:31]       data_out,
    output logic              io_ready,
    output logic              stall,
    output logic              wait_led
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        DONE,
        WAIT_RELEASE
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          rise;
    logic [CW-1:0] cnt;
    logic [0:31]   sw_ext;

    generate
        if (SW_WIDTH == 32) begin : g_noext
            assign sw_ext = sw;
        end else begin : g_ext
            assign sw_ext = {{(32 - SW_WIDTH){sw[0]}}, sw};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_enter;
            sync2 <= sync1;
        end
    end

    // Level only moves after DEBOUNCE_CYCLES consecutive differing samples;
    // the rise pulse is produced on the same edge the level goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb  <= 1'b0;
            rise <= 1'b0;
            cnt  <= '0;
        end else begin
            rise <= 1'b0;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb  <= sync2;
                rise <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_out <= '0;
            io_ready <= 1'b0;
            wait_led <= 1'b0;
        end else begin
            io_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_req) begin
                        state    <= WAIT_PRESS;
                        wait_led <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (rise) begin
                        data_out <= sw_ext;
                        io_ready <= 1'b1;
                        wait_led <= 1'b0;
                        state    <= DONE;
                    end else if (!in_req) begin
                        wait_led <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DONE: begin
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // A held button must be released before the next request
                    // can be served, so a back-to-back IN cannot reuse it.
                    if (!deb && !in_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_led <= 1'b0;
                end
            endcase
        end
    end

    assign stall = in_req && (state != DONE);

endmodule
